word_context_update_seq: RTL

//  Sequential, parametrised skip-gram update step. Accepts one (word, context, y_actual) sample
//  per handshake and computes y = dot(word, context) with optional hard-sigmoid. Then computes

---
 rtl/word_ctx_pkg.sv | 18 +
 rtl/fx_mul_shift.sv | 28 ++
 rtl/word_context_update_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/word_ctx_pkg.sv
// word_ctx_pkg: shared state encoding, default fixed-point widths and the saturation helper.
package word_ctx_pkg;

    typedef enum logic [2:0] {IDLE, DOT, ERR, UPD, DONE} state_t;

    localparam int FIX_W_DEF = 16;
    localparam int FRAC_DEF  = 8;

    // Clamp a wide signed value into the signed range of 'width' bits (width <= 63).
    function automatic logic signed [63:0] sat_fx(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// fx_mul_shift: signed a*b, arithmetic right shift by SHIFT, saturated to OUT_W bits.
//  i_a, i_b : signed W-bit operands
//  o_p      : saturated, shifted product (OUT_W bits)
//  o_sat    : high when the clamp changed the value
module fx_mul_shift
    import word_ctx_pkg::*;
#(
    parameter int W     = 16,
    parameter int SHIFT = 0,
    parameter int OUT_W = 2 * W
) (
    input  logic signed [W-1:0]     i_a,
    input  logic signed [W-1:0]     i_b,
    output logic signed [OUT_W-1:0] o_p,
    output logic                    o_sat
);

    logic signed [2*W-1:0] w_prod;
    logic signed [63:0]    w_shr;
    logic signed [63:0]    w_clip;

    assign w_prod = (2*W)'(i_a) * (2*W)'(i_b);
    assign w_shr  = 64'(w_prod) >>> SHIFT;
    assign w_clip = sat_fx(w_shr, OUT_W);
    assign o_p    = w_clip[OUT_W-1:0];
    assign o_sat  = w_clip != w_shr;

endmodule

// File: rtl/word_context_update_seq.sv
// word_context_update_seq: serial skip-gram update step (dot, error, scaled vector updates).
//  clk, rst_n           : clock, asynchronous active-low reset
//  i_in_valid/o_in_ready: sample handshake; sample registered on accept
//  i_y_actual           : target value
//  i_word_embv          : word vector, element i at [i*FIX_W +: FIX_W]
//  i_context_embv       : context vector, same packing
//  o_out_valid/i_out_ready : result handshake; results held while stalled
//  o_y, o_error         : prediction and y_actual - y
//  o_new_word_embv      : word + lr*error*context
//  o_new_context_embv   : context + lr*error*word
//  o_sat_flag           : any saturation during this sample
module word_context_update_seq
    import word_ctx_pkg::*;
#(
    parameter int DIM      = 3,
    parameter int FIX_W    = FIX_W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int LR_SHIFT = 2,
    parameter int MODE     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [FIX_W-1:0]       i_y_actual,
    input  logic [DIM*FIX_W-1:0]   i_word_embv,
    input  logic [DIM*FIX_W-1:0]   i_context_embv,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [FIX_W-1:0]       o_y,
    output logic [FIX_W-1:0]       o_error,
    output logic [DIM*FIX_W-1:0]   o_new_word_embv,
    output logic [DIM*FIX_W-1:0]   o_new_context_embv,
    output logic                   o_sat_flag
);

    localparam int ACC_W = 2 * FIX_W + $clog2(DIM + 1);
    localparam int IDX_W = DIM > 1 ? $clog2(DIM) : 1;
    // Two spare bits on the delta keep old+delta saturating exactly as with an unclamped delta.
    localparam int DW    = FIX_W + 2;
    localparam logic signed [FIX_W-1:0] ONE = FIX_W'(1 << FRAC);

    state_t r_state;
    state_t w_next;

    logic [IDX_W-1:0]           r_idx;
    logic [DIM*FIX_W-1:0]       r_w_vec;
    logic [DIM*FIX_W-1:0]       r_c_vec;
    logic [DIM*FIX_W-1:0]       r_nw_vec;
    logic [DIM*FIX_W-1:0]       r_nc_vec;
    logic signed [FIX_W-1:0]    r_ya;
    logic signed [FIX_W-1:0]    r_y;
    logic signed [FIX_W-1:0]    r_err;
    logic signed [ACC_W-1:0]    r_acc;
    logic                       r_sat;

    logic [FIX_W-1:0]           r_out_y;
    logic [FIX_W-1:0]           r_out_err;
    logic [DIM*FIX_W-1:0]       r_out_nw;
    logic [DIM*FIX_W-1:0]       r_out_nc;
    logic                       r_out_sat;
    logic                       r_out_valid;

    logic                       w_last;
    logic signed [FIX_W-1:0]    w_wi;
    logic signed [FIX_W-1:0]    w_ci;
    logic signed [2*FIX_W-1:0]  w_prod;
    logic                       w_dot_sat;
    logic signed [63:0]         w_y_sh;
    logic signed [63:0]         w_y_clip;
    logic signed [FIX_W-1:0]    w_y_lin;
    logic signed [FIX_W-1:0]    w_y;
    logic                       w_y_sat;
    logic signed [63:0]         w_e_diff;
    logic signed [63:0]         w_e_clip;
    logic                       w_e_sat;
    logic signed [DW-1:0]       w_dlt_w;
    logic signed [DW-1:0]       w_dlt_c;
    logic                       w_dlt_w_sat;
    logic                       w_dlt_c_sat;
    logic signed [63:0]         w_nw_sum;
    logic signed [63:0]         w_nc_sum;
    logic signed [63:0]         w_nw_clip;
    logic signed [63:0]         w_nc_clip;
    logic                       w_nw_sat;
    logic                       w_nc_sat;

    assign w_last = r_idx == IDX_W'(DIM - 1);
    assign w_wi   = r_w_vec[r_idx*FIX_W +: FIX_W];
    assign w_ci   = r_c_vec[r_idx*FIX_W +: FIX_W];

    fx_mul_shift #(.W(FIX_W), .SHIFT(0), .OUT_W(2*FIX_W)) u_dot (
        .i_a   (w_wi),
        .i_b   (w_ci),
        .o_p   (w_prod),
        .o_sat (w_dot_sat)
    );

    // Prediction: scale the accumulator back to Q format, saturate, optionally hard-sigmoid.
    assign w_y_sh   = 64'(r_acc) >>> FRAC;
    assign w_y_clip = sat_fx(w_y_sh, FIX_W);
    assign w_y_lin  = w_y_clip[FIX_W-1:0];
    assign w_y_sat  = w_y_clip != w_y_sh;
    assign w_y      = MODE != 0 ? (w_y_lin < 0 ? '0 : (w_y_lin > ONE ? ONE : w_y_lin)) : w_y_lin;
    assign w_e_diff = 64'(r_ya) - 64'(w_y);
    assign w_e_clip = sat_fx(w_e_diff, FIX_W);
    assign w_e_sat  = w_e_clip != w_e_diff;

    // Both updates use the original vectors, so one element of each is produced per cycle.
    fx_mul_shift #(.W(FIX_W), .SHIFT(FRAC + LR_SHIFT), .OUT_W(DW)) u_upd_w (
        .i_a   (r_err),
        .i_b   (w_ci),
        .o_p   (w_dlt_w),
        .o_sat (w_dlt_w_sat)
    );

    fx_mul_shift #(.W(FIX_W), .SHIFT(FRAC + LR_SHIFT), .OUT_W(DW)) u_upd_c (
        .i_a   (r_err),
        .i_b   (w_wi),
        .o_p   (w_dlt_c),
        .o_sat (w_dlt_c_sat)
    );

    assign w_nw_sum  = 64'(w_wi) + 64'(w_dlt_w);
    assign w_nc_sum  = 64'(w_ci) + 64'(w_dlt_c);
    assign w_nw_clip = sat_fx(w_nw_sum, FIX_W);
    assign w_nc_clip = sat_fx(w_nc_sum, FIX_W);
    assign w_nw_sat  = w_nw_clip != w_nw_sum;
    assign w_nc_sat  = w_nc_clip != w_nc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? DOT : IDLE;
            DOT:     w_next = w_last ? ERR : DOT;
            ERR:     w_next = UPD;
            UPD:     w_next = w_last ? DONE : UPD;
            DONE:    w_next = (r_out_valid && i_out_ready) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_w_vec     <= '0;
            r_c_vec     <= '0;
            r_nw_vec    <= '0;
            r_nc_vec    <= '0;
            r_ya        <= '0;
            r_y         <= '0;
            r_err       <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out_y     <= '0;
            r_out_err   <= '0;
            r_out_nw    <= '0;
            r_out_nc    <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_w_vec <= i_word_embv;
                    r_c_vec <= i_context_embv;
                    r_ya    <= i_y_actual;
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_sat   <= 1'b0;
                end
                DOT: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_sat <= r_sat | w_dot_sat;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                ERR: begin
                    r_y   <= w_y;
                    r_err <= w_e_clip[FIX_W-1:0];
                    r_sat <= r_sat | w_y_sat | w_e_sat;
                end
                UPD: begin
                    r_nw_vec[r_idx*FIX_W +: FIX_W] <= w_nw_clip[FIX_W-1:0];
                    r_nc_vec[r_idx*FIX_W +: FIX_W] <= w_nc_clip[FIX_W-1:0];
                    r_sat <= r_sat | w_dlt_w_sat | w_dlt_c_sat | w_nw_sat | w_nc_sat;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                DONE: begin
                    // First DONE cycle publishes the results; they then stay until the next sample's DONE.
                    if (!r_out_valid) begin
                        r_out_y     <= r_y;
                        r_out_err   <= r_err;
                        r_out_nw    <= r_nw_vec;
                        r_out_nc    <= r_nc_vec;
                        r_out_sat   <= r_sat;
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready         = r_state == IDLE;
    assign o_out_valid        = r_out_valid;
    assign o_y                = r_out_y;
    assign o_error            = r_out_err;
    assign o_new_word_embv    = r_out_nw;
    assign o_new_context_embv = r_out_nc;
    assign o_sat_flag         = r_out_sat;

endmodule
